// File: rtl/shift_deserializer_if.sv
// Bundle of the serial-bit input and parallel-word output handshakes of shift_deserializer.
// A bit moves when bitValid && bitReady at a rising edge; a word moves when dataValid && dataReady.
interface shift_deserializer_if #(
  parameter int Width = 8
);
  logic             shiftRight;
  logic             bitIn;
  logic             bitValid;
  logic             bitReady;
  logic [Width-1:0] dataOut;
  logic             dataValid;
  logic             dataReady;
  logic             parityErr;

  modport master (
    output shiftRight, bitIn, bitValid, dataReady,
    input  bitReady, dataOut, dataValid, parityErr
  );

  modport slave (
    input  shiftRight, bitIn, bitValid, dataReady,
    output bitReady, dataOut, dataValid, parityErr
  );
endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles Width bits MSB- or LSB-first into a one-deep output register.
// Optional even-parity bit after each word: define SHIFT_DESERIALIZER_PARITY_EN.
module shift_deserializer #(
  parameter int Width = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_deserializer_if.slave  bus,
  output logic [1:0]           state_o
);
  localparam int CW = $clog2(Width);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             dir_q;
  logic [Width-1:0] sr_q;
  logic [Width-1:0] data_q;
  logic             valid_q;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  logic             perr_q;
`endif

  logic             dir_d;
  logic [Width-1:0] sr_d;
  logic             last_data;
  logic             last_bit;
  logic             ready;
  logic             accept;
  logic             load_word;

  assign last_data = (state_q == DATA) && (cnt_q == CW'(Width - 1));
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  assign last_bit  = (state_q == PARITY);
`else
  assign last_bit  = last_data;
`endif

  // Only the bit that would complete a word can be stalled by a full output register.
  assign ready     = !rst && !(valid_q && !bus.dataReady && last_bit);
  assign accept    = bus.bitValid && ready;
  assign load_word = accept && last_bit;

  // Direction is taken live on the first bit of a word, then held for the rest of it.
  assign dir_d = (state_q == IDLE) ? bus.shiftRight : dir_q;
  assign sr_d  = dir_d ? {bus.bitIn, sr_q[Width-1:1]} : {sr_q[Width-2:0], bus.bitIn};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      if (valid_q && bus.dataReady && !load_word) begin
        valid_q <= 1'b0;
        data_q  <= '0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
        perr_q  <= 1'b0;
`endif
      end
      if (accept) begin
        case (state_q)
          IDLE: begin
            dir_q   <= bus.shiftRight;
            sr_q    <= sr_d;
            cnt_q   <= CW'(1);
            state_q <= DATA;
          end
          DATA: begin
            sr_q <= sr_d;
            if (cnt_q == CW'(Width - 1)) begin
              cnt_q   <= '0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= IDLE;
              data_q  <= sr_d;
              valid_q <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
          PARITY: begin
            data_q  <= sr_q;
            perr_q  <= (^sr_q) ^ bus.bitIn;
            valid_q <= 1'b1;
            state_q <= IDLE;
          end
`endif
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.bitReady  = ready;
  assign bus.dataOut   = data_q;
  assign bus.dataValid = valid_q;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  assign bus.parityErr = perr_q;
`else
  assign bus.parityErr = 1'b0;
`endif
  assign state_o = state_q;
endmodule

// File: tb/tb_shift_deserializer.sv
// Randomized scoreboard bench for shift_deserializer: words are picked as integers,
// serialized by bit index, and the expected word is queued for the output monitor.
module tb_shift_deserializer;
  localparam int W = 8;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  shift_deserializer_if #(.Width(W)) bif ();

  shift_deserializer #(.Width(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif),
    .state_o (dbg_state)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         stall_cnt = 0;
  int         ready_mode = 1;  // 0 = low, 1 = high, 2 = random
  logic [W:0] exp_q[$];        // {parityErr, word}
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  logic       next_par = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       bif.dataReady = 1'b0;
        1:       bif.dataReady = 1'b1;
        default: bif.dataReady = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic send_bit(input logic b, input logic sr_val, input logic is_last);
    int waited;
    @(negedge clk);
    bif.bitIn      = b;
    bif.shiftRight = sr_val;
    bif.bitValid   = 1'b1;
    #1;
    waited = 0;
    while (!bif.bitReady && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    stall_cnt += waited;
    if (!is_last) check("nonfinal_stall", waited, 0);
    if (!bif.bitReady) begin
      n_checks++;
      n_fail++;
      $display("FAIL bit_accept_timeout: bitReady stayed 0, required 1 at %0t", $time);
      bif.bitValid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // tmode: 0 = hold shiftRight, 1 = toggle every bit, 2 = random after first bit
  task automatic send_word(input logic [W-1:0] w, input logic dir, input int tmode);
    logic s;
    logic b;
    logic last;
    s = dir;
    for (int i = 0; i < W; i++) begin
      b = dir ? w[i] : w[W-1-i];
      if (i > 0) begin
        if (tmode == 1) s = ~s;
        else if (tmode == 2) s = 1'($urandom_range(0, 1));
      end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      last = 1'b0;
`else
      last = (i == W - 1);
`endif
      send_bit(b, s, last);
    end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    send_bit(next_par, ~s, 1'b1);
    exp_q.push_back({(^w) ^ next_par, w});
`else
    exp_q.push_back({1'b0, w});
`endif
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bif.bitValid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic       prev_hold;
    logic [W:0] prev_data;
    logic [W:0] e;
    prev_hold = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_hold = 1'b0;
      end else begin
        if (prev_hold) begin
          check("hold_valid", bif.dataValid, 1);
          check("hold_data", {bif.parityErr, bif.dataOut}, prev_data);
        end
        if (bif.dataValid && bif.dataReady) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h, required no word", bif.dataOut);
          end else begin
            e = exp_q.pop_front();
            check("word", {bif.parityErr, bif.dataOut}, e);
          end
        end
        prev_hold = bif.dataValid && !bif.dataReady;
        prev_data = {bif.parityErr, bif.dataOut};
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst            = 1'b1;
    bif.bitIn      = 1'b0;
    bif.bitValid   = 1'b0;
    bif.shiftRight = 1'b0;
    bif.dataReady  = 1'b1;
    #1;
    check("rst_bitready", bif.bitReady, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_bitready", bif.bitReady, 1);
    check("rel_valid", bif.dataValid, 0);
    check("rel_data", bif.dataOut, 0);

    // MSB-first 0,0,0,1,1,1,1,0 and LSB-first with toggling shiftRight
    send_word(8'h1E, 1'b0, 0);
    idle(3);
    send_word(8'h78, 1'b1, 1);
    idle(3);

    // backpressure: two back-to-back words while downstream is stalled
    ready_mode = 0;
    stall_cnt  = 0;
    fork
      begin
        send_word(8'hC3, 1'b0, 0);
        send_word(8'h5A, 1'b1, 0);
      end
      begin
        repeat (30) @(negedge clk);
        ready_mode = 1;
      end
    join
    check("bp_stalled", stall_cnt > 0, 1);
    idle(4);

    // reset mid-word with a held word and bitValid high
    ready_mode = 0;
    send_word(8'h3C, 1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
    @(negedge clk);
    bif.bitValid = 1'b1;
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_data", bif.dataOut, 0);
    check("mid_rst_valid", bif.dataValid, 0);
    check("mid_rst_bitready", bif.bitReady, 0);
    exp_q.delete();
    @(negedge clk);
    bif.bitValid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 1;
    #1;
    check("post_rst_bitready", bif.bitReady, 1);
    send_word(8'hA5, 1'b0, 0);
    idle(3);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
    next_par = 1'b0;
    send_word(8'h1E, 1'b0, 0);
    next_par = 1'b1;
    send_word(8'h1E, 1'b0, 0);
    idle(3);
`endif

    // randomized traffic with random downstream readiness
    ready_mode = 2;
    for (int k = 0; k < 40; k++) begin
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      next_par = 1'($urandom_range(0, 1));
`endif
      send_word(W'($urandom), 1'($urandom_range(0, 1)), 2);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end

    ready_mode = 1;
    idle(6);
    check("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
